fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the multi-cycle MIPS datapath.
- Owns the architectural PC register and drives a req/ready handshake to instruction memory.
- Hands fetched words to decode over a valid/ready interface.
- Accepts redirects (taken beq, jal, jr targets computed by the next-PC logic) and squashes wrong-path fetches.

---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the multi-cycle MIPS datapath.
// It owns the PC, issues one request at a time to instruction memory and hands
// each fetched word to decode over valid/ready. Redirects that arrive while a
// request is outstanding are parked in pend_q until the wrong-path word returns.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  input  logic             if_ready,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [0:0] {StFetch, StDeliver} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_target_q, pend_target_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Low for the cycle following a reset edge so no request is issued while the
  // memory side is still coming out of reset.
  logic               req_en_q;
  logic [31:0]        redirect_pc;

  assign redirect_pc = {redirect_target[31:2], 2'b00};

  // State register: all architectural and handshake state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= 32'h0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= 32'h0;
      cnt_q         <= '0;
      req_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      cnt_q         <= cnt_d;
      req_en_q      <= 1'b1;
    end
  end

  // Next-state logic: fetch/deliver sequencing, redirect and squash handling.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    cnt_d         = cnt_q;
    case (state_q)
      StFetch: begin
        if (req_en_q && imem_ready) begin
          if (pend_q || redirect_valid) begin
            // Wrong-path word: drop it and restart at the newest target.
            pc_d   = redirect_valid ? redirect_pc : pend_target_q;
            pend_d = 1'b0;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            state_d    = StDeliver;
          end
        end else if (redirect_valid) begin
          // Keep pc_q (and so imem_addr) stable while the request is pending.
          pend_d        = 1'b1;
          pend_target_d = redirect_pc;
        end
      end
      StDeliver: begin
        if (if_ready) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (if_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Outputs: decoded from registered state only.
  always_comb begin
    imem_req  = (state_q == StFetch) && req_en_q;
    imem_addr = pc_q;
    if_valid  = (state_q == StDeliver);
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
    fetch_cnt = cnt_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait streaming, wait states, decode
// stalls, redirects in both states, PC wrap and mid-operation reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_ready;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  logic [31:0] fetch_cnt;

  logic        imem_req2, if_valid2;
  logic [31:0] imem_addr2, if_pc2, if_instr2;
  logic [31:0] fetch_cnt2;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Key = 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address so delivered data is traceable.
  assign imem_rdata = imem_addr ^ Key;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .fetch_cnt      (fetch_cnt)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid2),
    .if_pc          (if_pc2),
    .if_instr       (if_instr2),
    .if_ready       (if_ready),
    .fetch_cnt      (fetch_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b0; if_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h exp 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h exp 0", if_instr); end
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", fetch_cnt); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr: got %h exp 3000", imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b exp 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    imem_ready = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3000 + 32'(4 * i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL zw_req%0d: got req=%0b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, a); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ Key)) begin errors++; $display("FAIL zw_deliver%0d: got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h", i, if_valid, if_pc, if_instr, a, a ^ Key); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_low%0d: got %0b exp 0", i, imem_req); end
      step();
    end
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL zw_cnt: got %0d exp 3", fetch_cnt); end
  endtask

  task automatic test_wait_stall();
    imem_ready = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C || if_valid !== 1'b0) begin errors++; $display("FAIL wait%0d: got req=%0b addr=%h v=%0b exp req=1 addr=300c v=0", i, imem_req, imem_addr, if_valid); end
      step();
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300C || if_instr !== (32'h300C ^ Key) || fetch_cnt !== 32'd3) begin errors++; $display("FAIL stall%0d: got v=%0b pc=%h instr=%h cnt=%0d exp v=1 pc=300c instr=%h cnt=3", i, if_valid, if_pc, if_instr, fetch_cnt, 32'h300C ^ Key); end
      if (i == 2) if_ready = 1'b1;
      step();
    end
    if_ready = 1'b0;
    checks++; if (fetch_cnt !== 32'd4 || if_valid !== 1'b0 || imem_addr !== 32'h3010) begin errors++; $display("FAIL stall_release: got cnt=%0d v=%0b addr=%h exp cnt=4 v=0 addr=3010", fetch_cnt, if_valid, imem_addr); end
  endtask

  task automatic test_redirect_fetch();
    redirect_valid = 1'b1; redirect_target = 32'h0000_3100;
    step();
    redirect_target = 32'h0000_3200;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010) begin errors++; $display("FAIL rf_stable: got req=%0b addr=%h exp req=1 addr=3010", imem_req, imem_addr); end
    imem_ready = 1'b1;
    step();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3200) begin errors++; $display("FAIL rf_discard: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=3200", if_valid, imem_req, imem_addr); end
    step();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3200 || fetch_cnt !== 32'd4) begin errors++; $display("FAIL rf_pend_clear: got v=%0b pc=%h cnt=%0d exp v=1 pc=3200 cnt=4", if_valid, if_pc, fetch_cnt); end
  endtask

  task automatic test_redirect_deliver();
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_3043;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3040 || fetch_cnt !== 32'd4) begin errors++; $display("FAIL rd_squash: got v=%0b addr=%h cnt=%0d exp v=0 addr=3040 cnt=4", if_valid, imem_addr, fetch_cnt); end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3040) begin errors++; $display("FAIL rd_refetch: got v=%0b pc=%h exp v=1 pc=3040", if_valid, if_pc); end
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3043;
    step();
    redirect_valid = 1'b0; if_ready = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3040 || fetch_cnt !== 32'd5) begin errors++; $display("FAIL rd_accept: got v=%0b addr=%h cnt=%0d exp v=0 addr=3040 cnt=5", if_valid, imem_addr, fetch_cnt); end
  endtask

  task automatic test_reset_mid();
    step();
    checks++; if (imem_req !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rm_waiting: got req=%0b v=%0b exp req=1 v=0", imem_req, if_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || fetch_cnt !== 32'h0 || imem_addr !== 32'h3000) begin errors++; $display("FAIL rm_reset: got req=%0b v=%0b pc=%h instr=%h cnt=%0d addr=%h exp all zero addr=3000", imem_req, if_valid, if_pc, if_instr, fetch_cnt, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL rm_first_req: got req=%0b addr=%h exp req=1 addr=3000", imem_req, imem_addr); end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin errors++; $display("FAIL rm_deliver: got v=%0b pc=%h exp v=1 pc=3000", if_valid, if_pc); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step();
    imem_ready = 1'b1; if_ready = 1'b1;
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req=%0b addr=%h exp req=1 addr=fffffffc", imem_req2, imem_addr2); end
    step();
    checks++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_deliver: got v=%0b pc=%h exp v=1 pc=fffffffc", if_valid2, if_pc2); end
    step();
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_second: got req=%0b addr=%h exp req=1 addr=0", imem_req2, imem_addr2); end
    imem_ready = 1'b0; if_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_stall();
    test_redirect_fetch();
    test_redirect_deliver();
    test_reset_mid();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
